// File: rtl/ibex_hpm_ctrl_if.sv
// Bus bundle between the CSR file / event sources (master) and ibex_hpm_ctrl (slave).
interface ibex_hpm_ctrl_if #(
    parameter int NumCounters = 4,
    parameter int NumEvents   = 16
);
    logic [NumEvents-1:0]          event_i;
    logic                          cfg_we_i;
    logic [5:0]                    cfg_addr_i;
    logic [31:0]                   cfg_wdata_i;
    logic [31:0]                   cfg_rdata_o;
    logic                          cnt_we_i;
    logic                          cnt_weh_i;
    logic [4:0]                    cnt_idx_i;
    logic [31:0]                   cnt_wdata_i;
    logic [64*NumCounters-1:0]     counter_val_i;
    logic [NumCounters-1:0]        counter_inc_o;
    logic [NumCounters-1:0]        counter_we_o;
    logic [NumCounters-1:0]        counterh_we_o;
    logic [31:0]                   counter_wdata_o;
    logic                          irq_o;

    modport master (
        output event_i, cfg_we_i, cfg_addr_i, cfg_wdata_i,
        output cnt_we_i, cnt_weh_i, cnt_idx_i, cnt_wdata_i, counter_val_i,
        input  cfg_rdata_o, counter_inc_o, counter_we_o, counterh_we_o,
        input  counter_wdata_o, irq_o
    );

    modport slave (
        input  event_i, cfg_we_i, cfg_addr_i, cfg_wdata_i,
        input  cnt_we_i, cnt_weh_i, cnt_idx_i, cnt_wdata_i, counter_val_i,
        output cfg_rdata_o, counter_inc_o, counter_we_o, counterh_we_o,
        output counter_wdata_o, irq_o
    );
endinterface

// File: rtl/ibex_hpm_ctrl.sv
// HPM counter-bank controller: event select, inhibit, CSR write forwarding, overflow IRQ.
// Overflow tracking (ovf/ovf_en regs, irq_o) is built only when IBEX_HPM_OVF_IRQ_EN is defined.
module ibex_hpm_lane #(
    parameter int NumEvents = 16,
    parameter int Idx       = 0
) (
    input  logic [NumEvents-1:0] event_q,
    input  logic [NumEvents-1:0] evsel,
    input  logic                 inhibit,
    input  logic                 cnt_we,
    input  logic                 cnt_weh,
    input  logic [4:0]           cnt_idx,
    output logic                 inc,
    output logic                 we,
    output logic                 weh
);
    logic hit;

    assign hit = (cnt_idx == 5'(Idx));
    // High write takes priority over a simultaneous low write.
    assign we  = cnt_we & ~cnt_weh & hit;
    assign weh = cnt_weh & hit;
    // A CSR write to this counter drops the coincident increment.
    assign inc = (|(event_q & evsel)) & ~inhibit & ~we & ~weh;
endmodule

module ibex_hpm_ctrl #(
    parameter int NumCounters  = 4,
    parameter int NumEvents    = 16,
    parameter int CounterWidth = 40
) (
    input logic             clk_i,
    input logic             rst_i,
    ibex_hpm_ctrl_if.slave  bus
);
    logic [NumEvents-1:0]                  event_q;
    logic [NumCounters-1:0]                inhibit;
    logic [NumCounters-1:0][NumEvents-1:0] evsel;
    logic [NumCounters-1:0]                inc, we, weh;
    logic                                  unused_in;

    assign unused_in = ^{bus.cfg_wdata_i, bus.counter_val_i};

    for (genvar k = 0; k < NumCounters; k++) begin : g_lane
        ibex_hpm_lane #(
            .NumEvents (NumEvents),
            .Idx       (k)
        ) u_lane (
            .event_q (event_q),
            .evsel   (evsel[k]),
            .inhibit (inhibit[k]),
            .cnt_we  (bus.cnt_we_i),
            .cnt_weh (bus.cnt_weh_i),
            .cnt_idx (bus.cnt_idx_i),
            .inc     (inc[k]),
            .we      (we[k]),
            .weh     (weh[k])
        );
    end

    assign bus.counter_inc_o   = inc;
    assign bus.counter_we_o    = we;
    assign bus.counterh_we_o   = weh;
    assign bus.counter_wdata_o = bus.cnt_wdata_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            event_q <= '0;
            inhibit <= '0;
            evsel   <= '0;
        end else begin
            event_q <= bus.event_i;
            if (bus.cfg_we_i) begin
                if (bus.cfg_addr_i == 6'd0)
                    inhibit <= bus.cfg_wdata_i[NumCounters-1:0];
                for (int k = 0; k < NumCounters; k++)
                    if (bus.cfg_addr_i == 6'(3 + k))
                        evsel[k] <= bus.cfg_wdata_i[NumEvents-1:0];
            end
        end
    end

`ifdef IBEX_HPM_OVF_IRQ_EN
    logic [NumCounters-1:0] ovf, ovf_en, ovf_set, ovf_clr;

    // Wrap is detected on the implemented width only; upper bits are don't-care.
    for (genvar k = 0; k < NumCounters; k++) begin : g_ovf
        assign ovf_set[k] = inc[k] & (&bus.counter_val_i[64*k +: CounterWidth]);
    end

    assign ovf_clr = (bus.cfg_we_i && bus.cfg_addr_i == 6'd1) ?
                     bus.cfg_wdata_i[NumCounters-1:0] : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf    <= '0;
            ovf_en <= '0;
        end else begin
            ovf <= (ovf & ~ovf_clr) | ovf_set;
            if (bus.cfg_we_i && bus.cfg_addr_i == 6'd2)
                ovf_en <= bus.cfg_wdata_i[NumCounters-1:0];
        end
    end

    assign bus.irq_o = |(ovf & ovf_en);
`else
    assign bus.irq_o = 1'b0;
`endif

    always_comb begin
        bus.cfg_rdata_o = '0;
        if (bus.cfg_addr_i == 6'd0)
            bus.cfg_rdata_o = 32'(inhibit);
`ifdef IBEX_HPM_OVF_IRQ_EN
        if (bus.cfg_addr_i == 6'd1)
            bus.cfg_rdata_o = 32'(ovf);
        if (bus.cfg_addr_i == 6'd2)
            bus.cfg_rdata_o = 32'(ovf_en);
`endif
        for (int k = 0; k < NumCounters; k++)
            if (bus.cfg_addr_i == 6'(3 + k))
                bus.cfg_rdata_o = 32'(evsel[k]);
    end
endmodule
